// File: rtl/sumador_sched.sv
// sumador_sched: shares one accumulating adder datapath among N_REQ requesters.
// A pending job is arbitrated in IDLE. The datapath is cleared for one cycle and
// then fed the winner's latched operands for the programmed number of accumulate
// cycles, or until the datapath reports an overflow. The result is returned with
// a one-cycle done pulse to the owner.
// Optional build macro: SUMADOR_SCHED_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin arbitration.
module sumador_sched #(
  parameter int unsigned NB_DATA = 3,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned NB_CNT  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*NB_DATA-1:0]   i_data1,
  input  logic [N_REQ*NB_DATA-1:0]   i_data2,
  input  logic [2*N_REQ-1:0]         i_sel,
  input  logic [N_REQ*NB_CNT-1:0]    i_ncycles,
  output logic [N_REQ-1:0]           o_grant,
  output logic [N_REQ-1:0]           o_done,
  output logic [2*NB_DATA-1:0]       o_result,
  output logic                       o_ovf,
  output logic                       o_busy,
  output logic [NB_DATA-1:0]         o_dp_data1,
  output logic [NB_DATA-1:0]         o_dp_data2,
  output logic [1:0]                 o_dp_sel,
  output logic                       o_dp_clr_n,
  input  logic [2*NB_DATA-1:0]       i_dp_data,
  input  logic                       i_dp_overflow
);

  localparam int unsigned NB_RES = 2 * NB_DATA;
  localparam int unsigned NB_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Registered state
  logic [1:0]         state;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;
  logic [NB_RES-1:0]  result;
  logic               ovf;
  logic               busy;
  logic [NB_DATA-1:0] dp_data1;
  logic [NB_DATA-1:0] dp_data2;
  logic [1:0]         dp_sel;
  logic               dp_clr_n;
  logic [NB_IDX-1:0]  ptr;
  logic [NB_IDX-1:0]  owner;
  logic [NB_CNT-1:0]  budget;
  logic [NB_CNT-1:0]  cnt;
  logic               ovf_seen;
  logic               zero_job;

  // Next-state values
  logic [1:0]         state_nxt;
  logic [N_REQ-1:0]   grant_nxt;
  logic [N_REQ-1:0]   done_nxt;
  logic [NB_RES-1:0]  result_nxt;
  logic               ovf_nxt;
  logic               busy_nxt;
  logic [NB_DATA-1:0] dp_data1_nxt;
  logic [NB_DATA-1:0] dp_data2_nxt;
  logic [1:0]         dp_sel_nxt;
  logic               dp_clr_n_nxt;
  logic [NB_IDX-1:0]  ptr_nxt;
  logic [NB_IDX-1:0]  owner_nxt;
  logic [NB_CNT-1:0]  budget_nxt;
  logic [NB_CNT-1:0]  cnt_nxt;
  logic               ovf_seen_nxt;
  logic               zero_job_nxt;

  // Arbiter result
  logic               win_found;
  logic [NB_IDX-1:0]  win_idx;
  logic [NB_IDX-1:0]  cand;

`ifdef SUMADOR_SCHED_FIXED_PRIO_EN
  // Fixed priority: lowest requesting index wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      cand = NB_IDX'(i);
      if (i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`else
  // Round-robin: nearest requester after the last owner wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = int'(N_REQ); off >= 1; off--) begin
      cand = NB_IDX'((int'(ptr) + off) % int'(N_REQ));
      if (i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  // Next-state and next-output logic of the job sequencer
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    done_nxt     = '0;
    result_nxt   = result;
    ovf_nxt      = ovf;
    dp_data1_nxt = dp_data1;
    dp_data2_nxt = dp_data2;
    dp_sel_nxt   = dp_sel;
    dp_clr_n_nxt = 1'b0;
    ptr_nxt      = ptr;
    owner_nxt    = owner;
    budget_nxt   = budget;
    cnt_nxt      = cnt;
    ovf_seen_nxt = ovf_seen;
    zero_job_nxt = zero_job;

    case (state)
      ST_IDLE: begin
        if (win_found) begin
          state_nxt    = ST_CLEAR;
          grant_nxt    = N_REQ'(1) << win_idx;
          owner_nxt    = win_idx;
          dp_data1_nxt = i_data1[win_idx*NB_DATA +: NB_DATA];
          dp_data2_nxt = i_data2[win_idx*NB_DATA +: NB_DATA];
          dp_sel_nxt   = i_sel[win_idx*2 +: 2];
          budget_nxt   = i_ncycles[win_idx*NB_CNT +: NB_CNT];
        end
      end

      ST_CLEAR: begin
        cnt_nxt      = budget;
        ovf_seen_nxt = 1'b0;
        zero_job_nxt = (budget == '0);
        if (budget == '0) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt    = ST_RUN;
          dp_clr_n_nxt = 1'b1;
        end
      end

      ST_RUN: begin
        cnt_nxt = cnt - NB_CNT'(1);
        if (i_dp_overflow) begin
          ovf_seen_nxt = 1'b1;
        end
        if ((cnt == NB_CNT'(1)) || i_dp_overflow) begin
          state_nxt = ST_DONE;
        end else begin
          dp_clr_n_nxt = 1'b1;
        end
      end

      ST_DONE: begin
        result_nxt = zero_job ? '0 : i_dp_data;
        ovf_nxt    = ovf_seen;
        done_nxt   = grant;
        grant_nxt  = '0;
        ptr_nxt    = owner;
        state_nxt  = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      done     <= '0;
      result   <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      dp_data1 <= '0;
      dp_data2 <= '0;
      dp_sel   <= '0;
      dp_clr_n <= 1'b0;
      ptr      <= NB_IDX'(N_REQ - 1);
      owner    <= '0;
      budget   <= '0;
      cnt      <= '0;
      ovf_seen <= 1'b0;
      zero_job <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      done     <= done_nxt;
      result   <= result_nxt;
      ovf      <= ovf_nxt;
      busy     <= busy_nxt;
      dp_data1 <= dp_data1_nxt;
      dp_data2 <= dp_data2_nxt;
      dp_sel   <= dp_sel_nxt;
      dp_clr_n <= dp_clr_n_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      budget   <= budget_nxt;
      cnt      <= cnt_nxt;
      ovf_seen <= ovf_seen_nxt;
      zero_job <= zero_job_nxt;
    end
  end

  assign o_grant    = grant;
  assign o_done     = done;
  assign o_result   = result;
  assign o_ovf      = ovf;
  assign o_busy     = busy;
  assign o_dp_data1 = dp_data1;
  assign o_dp_data2 = dp_data2;
  assign o_dp_sel   = dp_sel;
  assign o_dp_clr_n = dp_clr_n;

endmodule

// File: tb/tb_sumador_sched.sv
// Testbench for sumador_sched: a behavioural accumulator stands in for the shared
// datapath, and job outcomes and arbitration order come from an arithmetic model.
module tb_sumador_sched;

  localparam int unsigned NB_DATA = 3;
  localparam int unsigned N_REQ   = 4;
  localparam int unsigned NB_CNT  = 8;
  localparam int unsigned NB_RES  = 2 * NB_DATA;
  localparam int unsigned NB_SUM  = NB_RES + 1;
  localparam int unsigned NB_IDX  = 2;
  localparam int          MODV    = 64;

  logic                     clk;
  logic                     rst_n;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*NB_DATA-1:0] data1;
  logic [N_REQ*NB_DATA-1:0] data2;
  logic [2*N_REQ-1:0]       sel;
  logic [N_REQ*NB_CNT-1:0]  ncycles;
  logic [N_REQ-1:0]         grant;
  logic [N_REQ-1:0]         done;
  logic [NB_RES-1:0]        result;
  logic                     ovf;
  logic                     busy;
  logic [NB_DATA-1:0]       dp_data1;
  logic [NB_DATA-1:0]       dp_data2;
  logic [1:0]               dp_sel;
  logic                     dp_clr_n;
  logic [NB_RES-1:0]        dp_data;
  logic                     dp_overflow;

  int n_checks;
  int n_fail;
  int d1_a [N_REQ];
  int d2_a [N_REQ];
  int sel_a[N_REQ];
  int n_a  [N_REQ];
  int mptr;
  int last_res;
  int rr_seen[$];

  sumador_sched #(.NB_DATA(NB_DATA), .N_REQ(N_REQ), .NB_CNT(NB_CNT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .i_data1(data1), .i_data2(data2), .i_sel(sel), .i_ncycles(ncycles),
    .o_grant(grant), .o_done(done), .o_result(result), .o_ovf(ovf), .o_busy(busy),
    .o_dp_data1(dp_data1), .o_dp_data2(dp_data2), .o_dp_sel(dp_sel),
    .o_dp_clr_n(dp_clr_n), .i_dp_data(dp_data), .i_dp_overflow(dp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared accumulator: cleared while clr_n is low, otherwise adds both operands
  logic [NB_RES-1:0] acc;
  logic              acc_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (!dp_clr_n) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else begin
      {acc_ovf, acc} <= NB_SUM'(acc) + NB_SUM'(dp_data1) + NB_SUM'(dp_data2);
    end
  end
  assign dp_data     = acc;
  assign dp_overflow = acc_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    for (int k = 0; k < int'(N_REQ); k++) begin
      data1[k*NB_DATA +: NB_DATA] = NB_DATA'(d1_a[k]);
      data2[k*NB_DATA +: NB_DATA] = NB_DATA'(d2_a[k]);
      sel[k*2 +: 2]               = 2'(sel_a[k]);
      ncycles[k*NB_CNT +: NB_CNT] = NB_CNT'(n_a[k]);
    end
  endtask

  task automatic rand_ops(input int nmax);
    for (int k = 0; k < int'(N_REQ); k++) begin
      d1_a[k]  = int'($urandom_range(0, 7));
      d2_a[k]  = int'($urandom_range(0, 7));
      sel_a[k] = int'($urandom_range(0, 3));
      n_a[k]   = int'($urandom_range(0, nmax));
    end
  endtask

  // Arbitration order from the request mask and the last owner
  function automatic int winner(input logic [N_REQ-1:0] m, input int p);
    int idx;
`ifdef SUMADOR_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < int'(N_REQ); i++) begin
      idx = i;
      if (m[NB_IDX'(idx)]) return idx;
    end
`else
    for (int off = 1; off <= int'(N_REQ); off++) begin
      idx = (p + off) % int'(N_REQ);
      if (m[NB_IDX'(idx)]) return idx;
    end
`endif
    return 0;
  endfunction

  // Job outcome: the sum wraps after k accumulations; the overflow flag is seen
  // one accumulate cycle later if the budget still allows it.
  function automatic void job_model(input int a, input int b, input int n,
                                    output int res, output bit ov, output int runs);
    int s;
    int k;
    s    = a + b;
    ov   = 1'b0;
    runs = n;
    if (s > 0) begin
      k = (MODV + s - 1) / s;
      if (k + 1 <= n) begin
        runs = k + 1;
        ov   = 1'b1;
      end
    end
    res = (runs * s) % MODV;
  endfunction

  task automatic run_job(input logic [N_REQ-1:0] mask, input bit scramble);
    int w;
    int res;
    int runs;
    int gcnt;
    int t;
    bit ov;
    logic [N_REQ-1:0] oh;
    @(negedge clk);
    req = mask;
    drive_ops();
    w  = winner(mask, mptr);
    oh = N_REQ'(1) << w;
    job_model(d1_a[w], d2_a[w], n_a[w], res, ov, runs);
    t = 0;
    while (grant == '0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    rr_seen.push_back(w);
    chk("grant_owner", 32'(grant), 32'(oh));
    chk("dp_data1", 32'(dp_data1), 32'(d1_a[w]));
    chk("dp_data2", 32'(dp_data2), 32'(d2_a[w]));
    chk("dp_sel", 32'(dp_sel), 32'(sel_a[w]));
    chk("busy_job", 32'(busy), 32'd1);
    if (scramble) begin
      rand_ops(40);
      drive_ops();
      req[NB_IDX'(w)] = 1'b0;
    end
    gcnt = 1;
    t = 0;
    while (t < 300) begin
      @(negedge clk);
      t++;
      if (done != '0) break;
      if (grant == oh) gcnt++;
    end
    chk("done_owner", 32'(done), 32'(oh));
    chk("grant_clear", 32'(grant), 32'd0);
    chk("result", 32'(result), 32'(res));
    chk("ovf", 32'(ovf), 32'(ov));
    chk("grant_cycles", 32'(gcnt), 32'(runs + 2));
    req      = '0;
    mptr     = w;
    last_res = res;
    @(negedge clk);
    chk("done_width", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = int'(N_REQ) - 1;
  endtask

  initial begin
    int seen;
    int t;
    logic [N_REQ-1:0] m;
    n_checks = 0;
    n_fail   = 0;
    mptr     = int'(N_REQ) - 1;
    last_res = 0;
    rst_n    = 1'b0;
    req      = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      d1_a[k] = 0; d2_a[k] = 0; sel_a[k] = 0; n_a[k] = 0;
    end
    drive_ops();

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dp_data1", 32'(dp_data1), 32'd0);
    chk("rst_dp_data2", 32'(dp_data2), 32'd0);
    chk("rst_dp_sel", 32'(dp_sel), 32'd0);
    chk("rst_dp_clr_n", 32'(dp_clr_n), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_clr_n", 32'(dp_clr_n), 32'd0);

    // Single job: 5 accumulations of 1+1
    d1_a[0] = 1; d2_a[0] = 1; sel_a[0] = 1; n_a[0] = 5;
    run_job(4'b0001, 1'b0);
    chk("single_result_10", 32'(result), 32'd10);
    repeat (3) @(negedge clk);
    chk("result_hold", 32'(result), 32'(last_res));

    // Overflow ends the job early
    d1_a[1] = 1; d2_a[1] = 1; sel_a[1] = 2; n_a[1] = 40;
    run_job(4'b0010, 1'b0);
    chk("ovf_result_2", 32'(result), 32'd2);
    chk("ovf_flag", 32'(ovf), 32'd1);

    // Zero budget
    d1_a[2] = 3; d2_a[2] = 4; sel_a[2] = 3; n_a[2] = 0;
    run_job(4'b0100, 1'b0);

    // Arbitration with every requester pending, from a fresh reset
    pulse_reset();
    rr_seen.delete();
    for (int k = 0; k < int'(N_REQ); k++) begin
      d1_a[k] = k + 1; d2_a[k] = 2; sel_a[k] = k; n_a[k] = 2;
    end
    repeat (5) run_job(4'b1111, 1'b0);
`ifdef SUMADOR_SCHED_FIXED_PRIO_EN
    chk("order_4", 32'(rr_seen[4]), 32'd0);
    chk("order_1", 32'(rr_seen[1]), 32'd0);
`else
    chk("order_1", 32'(rr_seen[1]), 32'd1);
    chk("order_3", 32'(rr_seen[3]), 32'd3);
    chk("order_4", 32'(rr_seen[4]), 32'd0);
`endif

    // Random masks and operands; some jobs change inputs and drop the request mid-job
    for (int it = 0; it < 25; it++) begin
      rand_ops(40);
      m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      run_job(m, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a job
    d1_a[3] = 1; d2_a[3] = 1; sel_a[3] = 0; n_a[3] = 30;
    @(negedge clk);
    req = 4'b1000;
    drive_ops();
    t = 0;
    while (grant == '0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("midrst_grant_before", 32'(grant), 32'b1000);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_clr_n", 32'(dp_clr_n), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done != '0 || grant != '0) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
